// File: rtl/font_banner_writer.sv
// font_banner_writer: renders a CHARS-glyph text line into the banner frame
// buffer. Each glyph row is fetched from the font ROM and written out one
// 12-bit pixel per clock, in raster order (row, then char, then column).
// Optional build macro: FONT_TRANSPARENT_EN. When it is defined, background
// pixels are skipped (ram_we low) so that previous RAM contents show through.
module font_banner_writer #(
  parameter int          CHARS    = 10,
  parameter int          GLYPH_W  = 32,
  parameter int          GLYPH_H  = 50,
  parameter int          BANNER_W = 320,
  parameter logic [11:0] FG_COLOR = 12'hFF0,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHARS*6-1:0]   text_codes,
  output logic                 busy,
  output logic                 done,
  output logic [11:0]          rom_addr,
  input  logic [31:0]          rom_data,
  output logic                 ram_we,
  output logic [13:0]          ram_addr,
  output logic [11:0]          ram_wdata
);

  localparam int CHAR_W = $clog2(CHARS);
  localparam int COL_W  = $clog2(GLYPH_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CHARS*6-1:0]  r_text;
  logic [5:0]          r_row;
  logic [CHAR_W-1:0]   r_char;
  logic [COL_W-1:0]    r_col;
  logic [31:0]         r_shift;
  logic                r_ram_we;
  logic [13:0]         r_ram_addr;
  logic [11:0]         r_ram_wdata;

  logic [5:0]          w_code;
  logic [13:0]         w_base;
  logic                w_last_col;
  logic                w_last_char;
  logic                w_last_row;

  assign w_code      = r_text[6*r_char +: 6];
  assign w_base      = 14'(int'(r_row) * BANNER_W + int'(r_char) * GLYPH_W);
  assign w_last_col  = (r_col  == COL_W'(GLYPH_W - 1));
  assign w_last_char = (r_char == CHAR_W'(CHARS - 1));
  assign w_last_row  = (r_row  == 6'(GLYPH_H - 1));

  assign rom_addr  = {w_code, r_row};
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

  function automatic logic [11:0] pixelColor(input logic bitVal);
    return bitVal ? FG_COLOR : BG_COLOR;
  endfunction

  function automatic logic pixelEnable(input logic bitVal);
`ifdef FONT_TRANSPARENT_EN
    return bitVal;
`else
    return 1'b1 | bitVal;
`endif
  endfunction

  // State register; reset aborts a render immediately, leaving the RAM as is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the status outputs that follow directly from state
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        busy         = 1'b1;
        w_state_next = S_LATCH;
      end
      S_LATCH: begin
        busy         = 1'b1;
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (w_last_col) begin
          w_state_next = (w_last_char && w_last_row) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: text latch, traversal counters, glyph shifter and registered RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_text      <= '0;
      r_row       <= '0;
      r_char      <= '0;
      r_col       <= '0;
      r_shift     <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_text     <= text_codes;
            r_row      <= '0;
            r_char     <= '0;
            r_col      <= '0;
            r_ram_addr <= '0;
          end
        end
        S_LATCH: begin
          r_shift     <= {rom_data[30:0], 1'b0};
          r_ram_wdata <= pixelColor(rom_data[31]);
          r_ram_we    <= pixelEnable(rom_data[31]);
          r_ram_addr  <= w_base;
          r_col       <= '0;
        end
        S_WRITE: begin
          if (w_last_col) begin
            r_col    <= '0;
            r_ram_we <= 1'b0;
            if (w_last_char) begin
              r_char <= '0;
              if (!w_last_row) begin
                r_row <= r_row + 6'd1;
              end
            end else begin
              r_char <= r_char + CHAR_W'(1);
            end
          end else begin
            r_col       <= r_col + COL_W'(1);
            r_shift     <= {r_shift[30:0], 1'b0};
            r_ram_wdata <= pixelColor(r_shift[31]);
            r_ram_we    <= pixelEnable(r_shift[31]);
            r_ram_addr  <= r_ram_addr + 14'd1;
          end
        end
        default: begin
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_font_banner_writer.sv
// Testbench for font_banner_writer: a pixel-level model of the banner image
// (built from glyph codes and ROM words by screen coordinate) is compared
// against every RAM write, plus hand-derived spot pixels and timing checks.
module tb_font_banner_writer;

  localparam int NPIX = 16000;
`ifdef FONT_TRANSPARENT_EN
  localparam logic [11:0] BG_SEEN        = 12'hABC;
  localparam int          PATTERN_WRITES = 1000;
`else
  localparam logic [11:0] BG_SEEN        = 12'h000;
  localparam int          PATTERN_WRITES = 16000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [59:0] text_codes;
  logic        busy;
  logic        done;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [11:0] ram_wdata;

  font_banner_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .text_codes (text_codes),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata)
  );

  always #5 clk = ~clk;

  int          romMode;
  logic [31:0] romRand [4096];

  function automatic logic [31:0] romWord(input logic [11:0] a);
    case (romMode)
      0:       return 32'h8000_0001;
      1:       return {20'h0, a};
      default: return romRand[a];
    endcase
  endfunction

  // Font ROM with one-cycle synchronous read
  always @(posedge clk) rom_data <= romWord(rom_addr);

  logic [59:0] modelCodes;
  logic [11:0] expImg [NPIX];
  logic [11:0] capImg [NPIX];
  int          expAddrs [$];
  int          busyCount, doneCount, doneAt, writeCount;
  int          orderErr, dataErr, romErr, stray;
  logic [11:0] fetchAddr [2];
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic buildModel();
    expAddrs.delete();
    for (int y = 0; y < 50; y++) begin
      for (int x = 0; x < 320; x++) begin
        logic [5:0]  c;
        logic [31:0] w;
        logic        b;
        c = modelCodes[(x / 32) * 6 +: 6];
        w = romWord({c, 6'(y)});
        b = w[31 - (x % 32)];
        expImg[x + y * 320] = b ? 12'hFF0 : 12'h000;
`ifdef FONT_TRANSPARENT_EN
        if (b) expAddrs.push_back(x + y * 320);
`else
        expAddrs.push_back(x + y * 320);
`endif
      end
    end
  endtask

  task automatic clearStats();
    busyCount = 0; doneCount = 0; doneAt = 0; writeCount = 0;
    orderErr = 0; dataErr = 0; romErr = 0; stray = 0;
    fetchAddr[0] = 12'hFFF; fetchAddr[1] = 12'hFFF;
    for (int i = 0; i < NPIX; i++) capImg[i] = 12'hABC;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    if (busy) busyCount++;
    if (done) begin
      doneCount++;
      doneAt = busyCount;
    end
    if (busy && busyCount <= 17000 && ((busyCount - 1) % 34) == 0) begin
      int n;
      logic [11:0] e;
      n = (busyCount - 1) / 34;
      e = {modelCodes[(n % 10) * 6 +: 6], 6'(n / 10)};
      if (n < 2) fetchAddr[n] = rom_addr;
      if (rom_addr !== e) romErr++;
    end
    if (ram_we === 1'b1) begin
      if (!busy) stray++;
      if (writeCount < expAddrs.size()) begin
        if (int'(ram_addr) != expAddrs[writeCount]) orderErr++;
      end else begin
        orderErr++;
      end
      if (int'(ram_addr) < NPIX) begin
        if (ram_wdata !== expImg[ram_addr]) dataErr++;
        capImg[ram_addr] = ram_wdata;
      end else begin
        dataErr++;
      end
      writeCount++;
    end
    #1;
  endtask

  task automatic applyStimulus(input int mode, input logic [59:0] codes);
    romMode    = mode;
    text_codes = codes;
    modelCodes = codes;
    buildModel();
    clearStats();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  task automatic runToDone(input int pulseA, input int pulseB, input int textAt,
                           input logic [59:0] altCodes, input bit holdStart);
    int guard;
    guard = 0;
    while (doneCount == 0 && guard < 20000) begin
      start = (busyCount == pulseA) || (busyCount == pulseB) || (holdStart && busyCount >= 16990);
      if (busyCount == textAt) text_codes = altCodes;
      stepCycle();
      guard++;
    end
  endtask

  task automatic checkRender(input string tag);
    checkOutput({tag, ".doneAt"},   doneAt, 17001);
    checkOutput({tag, ".writes"},   writeCount, expAddrs.size());
    checkOutput({tag, ".orderErr"}, orderErr, 0);
    checkOutput({tag, ".dataErr"},  dataErr, 0);
    checkOutput({tag, ".romErr"},   romErr, 0);
    checkOutput({tag, ".stray"},    stray, 0);
  endtask

  initial begin
    logic [59:0] codes;

    // Reset state before any clock edge
    rst_n = 1'b0; start = 1'b0; text_codes = '0; romMode = 0; modelCodes = '0;
    clearStats();
    #1;
    checkOutput("rst.busy",     busy, 0);
    checkOutput("rst.done",     done, 0);
    checkOutput("rst.ram_we",   ram_we, 0);
    checkOutput("rst.ram_addr", ram_addr, 0);
    checkOutput("rst.wdata",    ram_wdata, 0);
    checkOutput("rst.rom_addr", rom_addr, 0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    stepCycle(); stepCycle();
    checkOutput("idle.busy", busy, 0);

    // Render 1: every glyph row is 8000_0001, all codes 1
    $display("[TB] render 1: pattern ROM");
    for (int i = 0; i < 10; i++) codes[i*6 +: 6] = 6'd1;
    applyStimulus(0, codes);
    runToDone(0, 0, 0, codes, 1'b0);
    repeat (5) stepCycle();
    checkRender("r1");
    checkOutput("r1.doneCount", doneCount, 1);
    checkOutput("r1.busyAfter", busy, 0);
    checkOutput("r1.writes16k", writeCount, PATTERN_WRITES);
    checkOutput("r1.px0",   capImg[0],   12'hFF0);
    checkOutput("r1.px31",  capImg[31],  12'hFF0);
    checkOutput("r1.px32",  capImg[32],  12'hFF0);
    checkOutput("r1.px319", capImg[319], 12'hFF0);
    checkOutput("r1.px320", capImg[320], 12'hFF0);
    checkOutput("r1.px1",   capImg[1],   BG_SEEN);
    checkOutput("r1.px30",  capImg[30],  BG_SEEN);
    checkOutput("r1.px318", capImg[318], BG_SEEN);

    // Render 2: address-echo ROM, codes 0..9, restarts ignored, text changed mid-render
    $display("[TB] render 2: ROM addressing, start while busy, text latch");
    for (int i = 0; i < 10; i++) codes[i*6 +: 6] = 6'(i);
    applyStimulus(1, codes);
    runToDone(100, 9000, 50, {10{6'h2A}}, 1'b0);
    start = 1'b0;
    repeat (5) stepCycle();
    checkRender("r2");
    checkOutput("r2.doneCount", doneCount, 1);
    checkOutput("r2.fetch0",    fetchAddr[0], 12'h000);
    checkOutput("r2.fetch1",    fetchAddr[1], 12'h040);
    checkOutput("r2.px57",      capImg[57],  12'hFF0);
    checkOutput("r2.px58",      capImg[58],  BG_SEEN);
    checkOutput("r2.px351",     capImg[351], 12'hFF0);

    // Render 3: random ROM and codes, start held high through DONE
    $display("[TB] render 3: random ROM and codes");
    for (int i = 0; i < 4096; i++) romRand[i] = $urandom;
    for (int i = 0; i < 10; i++) codes[i*6 +: 6] = 6'($urandom_range(0, 63));
    applyStimulus(2, codes);
    runToDone(0, 0, 0, codes, 1'b1);
    checkRender("r3");
    stepCycle();
    checkOutput("r3.idleGap", busy, 0);
    clearStats();
    stepCycle();
    checkOutput("r4.restart", busy, 1);
    start = 1'b0;

    // Render 4 aborted by asynchronous reset in the middle of a WRITE run
    while (busyCount < 500 && busyCount > 0) stepCycle();
    checkOutput("r4.addr500", ram_addr, 469);
    checkOutput("r4.orderErr", orderErr, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst2.busy",     busy, 0);
    checkOutput("rst2.done",     done, 0);
    checkOutput("rst2.ram_we",   ram_we, 0);
    checkOutput("rst2.ram_addr", ram_addr, 0);
    stepCycle();
    #1;
    rst_n = 1'b1;
    repeat (3) stepCycle();
    checkOutput("rst2.idle",   busy, 0);
    checkOutput("rst2.we",     ram_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
